collision_detector: RTL and testbench

- Downstream consumer of the obstacle list that obstacle_generator drives, and of the player lane/jump that gamefsm forwards.
- Decides once per check strobe whether the player has hit an active obstacle and produces the `died` input to gamefsm, replacing the constant 0.
- Sequential: snapshots the obstacle array, scans it one entry per cycle, and tracks the player's airborne window across checks.

---
 rtl/collision_detector_pkg.sv | 22 ++
 rtl/collision_detector_jump_tracker.sv | 28 ++
 rtl/collision_detector.sv | 101 ++++++++++
 tb/tb_collision_detector.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/collision_detector_pkg.sv
// collision_detector_pkg: obstacle record, type codes, FSM states and hit window defaults.
package collision_detector_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam logic [1:0] OBS_LOW = 2'b00;
  localparam logic [1:0] OBS_TALL = 2'b01;
  localparam logic [1:0] OBS_PICKUP = 2'b10;
  localparam int NUM_OBSTACLES_DEF = 10;
  localparam logic [10:0] HIT_MIN_DEF = 11'd0;
  localparam logic [10:0] HIT_MAX_DEF = 11'd40;
  localparam logic [3:0] AIR_CHECKS_DEF = 4'd8;
  typedef struct packed {
    logic [1:0] kind;
    logic [10:0] position;
    logic [1:0] lane;
    logic active;
  } obstacle_t;
  // Type 2'b11 falls through as TALL: only PICKUP is harmless and only LOW is jumpable.
  function automatic logic collides(obstacle_t o, logic [1:0] lane, logic air, logic [10:0] lo, logic [10:0] hi);
    return o.active && o.lane == lane && o.position >= lo && o.position <= hi &&
           o.kind != OBS_PICKUP && !(o.kind == OBS_LOW && air);
  endfunction
endpackage

// File: rtl/collision_detector_jump_tracker.sv
// jump_tracker: turns jump rising edges into an airborne window counted in accepted checks.
module jump_tracker
  import collision_detector_pkg::*;
#(
  parameter logic [3:0] AIR_CHECKS = AIR_CHECKS_DEF
) (
  input  logic clk_65mhz,
  input  logic rst_n,
  input  logic clear,
  input  logic jump,
  input  logic tick,
  output logic airborne
);
  logic jump_q;
  logic [3:0] count;
  assign airborne = count != 4'd0;
  always_ff @(posedge clk_65mhz) begin
    if (!rst_n) begin
      jump_q <= 1'b0;
      count <= 4'd0;
    end else begin
      jump_q <= jump;
      if (clear) count <= 4'd0;
      else if (jump && !jump_q && count == 4'd0) count <= AIR_CHECKS;
      else if (tick && count != 4'd0) count <= count - 4'd1;
    end
  end
endmodule

// File: rtl/collision_detector.sv
// collision_detector: scans a snapshot of the obstacle list per check strobe and raises a sticky died flag.
module collision_detector
  import collision_detector_pkg::*;
#(
  parameter int NUM_OBSTACLES = NUM_OBSTACLES_DEF,
  parameter logic [10:0] HIT_MIN = HIT_MIN_DEF,
  parameter logic [10:0] HIT_MAX = HIT_MAX_DEF,
  parameter logic [3:0] AIR_CHECKS = AIR_CHECKS_DEF
) (
  input  logic clk_65mhz,
  input  logic rst_n,
  input  logic game_reset,
  input  logic playing,
  input  logic check,
  input  obstacle_t [NUM_OBSTACLES-1:0] obstacles,
  input  logic [1:0] lane,
  input  logic jump,
  output logic busy,
  output logic done,
  output logic died,
  output logic [3:0] hit_index,
  output logic [1:0] hit_type,
  output logic airborne,
  output logic overrun
);
  state_t state, state_n;
  obstacle_t [NUM_OBSTACLES-1:0] snap;
  logic [1:0] snap_lane;
  logic snap_play, snap_air;
  logic [3:0] idx, found_idx;
  logic [1:0] found_type;
  logic found, accept, last, hit_now;
  jump_tracker #(.AIR_CHECKS(AIR_CHECKS)) u_jump (
    .clk_65mhz(clk_65mhz),
    .rst_n(rst_n),
    .clear(game_reset),
    .jump(jump),
    .tick(accept),
    .airborne(airborne)
  );
  always_comb begin
    accept = check && state == IDLE && !game_reset;
    last = idx == 4'(NUM_OBSTACLES - 1);
    hit_now = state == SCAN && collides(snap[idx], snap_lane, snap_air, HIT_MIN, HIT_MAX);
    state_n = game_reset ? IDLE :
              state == IDLE ? (check ? SCAN : IDLE) :
              state == SCAN ? (last ? DONE : SCAN) : IDLE;
    busy = state == SCAN;
    done = state == DONE;
  end
  always_ff @(posedge clk_65mhz) begin
    if (!rst_n) begin
      state <= IDLE;
      snap <= '0;
      snap_lane <= 2'd0;
      snap_play <= 1'b0;
      snap_air <= 1'b0;
      idx <= 4'd0;
      found <= 1'b0;
      found_idx <= 4'd0;
      found_type <= 2'd0;
      died <= 1'b0;
      hit_index <= 4'd0;
      hit_type <= 2'd0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      if (game_reset) begin
        found <= 1'b0;
        died <= 1'b0;
        hit_index <= 4'd0;
        hit_type <= 2'd0;
        overrun <= 1'b0;
      end else begin
        if (check && state != IDLE) overrun <= 1'b1;
        if (accept) begin
          snap <= obstacles;
          snap_lane <= lane;
          snap_play <= playing;
          snap_air <= airborne;
          idx <= 4'd0;
          found <= 1'b0;
        end
        if (state == SCAN) begin
          idx <= idx + 4'd1;
          if (hit_now && !found) begin
            found <= 1'b1;
            found_idx <= idx;
            found_type <= snap[idx].kind;
          end
          // Commit on the last scan edge so died rises together with done.
          if (last && (found || hit_now) && snap_play && !died) begin
            died <= 1'b1;
            hit_index <= found ? found_idx : idx;
            hit_type <= found ? found_type : snap[idx].kind;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_collision_detector.sv
// tb_collision_detector: directed scenarios for scan timing, hit rules, airborne window, overrun and aborts.
module tb_collision_detector;
  import collision_detector_pkg::*;
  logic clk_65mhz = 1'b0;
  logic rst_n, game_reset, playing, check, jump;
  obstacle_t [9:0] obs;
  logic [1:0] lane;
  logic busy, done, died, airborne, overrun;
  logic [3:0] hit_index;
  logic [1:0] hit_type;
  int total = 0;
  int bad = 0;
  int lat, pulses;
  logic died_at_done;

  collision_detector dut (
    .clk_65mhz(clk_65mhz), .rst_n(rst_n), .game_reset(game_reset), .playing(playing),
    .check(check), .obstacles(obs), .lane(lane), .jump(jump), .busy(busy), .done(done),
    .died(died), .hit_index(hit_index), .hit_type(hit_type), .airborne(airborne), .overrun(overrun)
  );

  always #5 clk_65mhz = ~clk_65mhz;

  function automatic obstacle_t mk(logic [1:0] k, logic [10:0] p, logic [1:0] l);
    return '{kind: k, position: p, lane: l, active: 1'b1};
  endfunction

  task automatic tick();
    @(posedge clk_65mhz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic do_check(output int l, output logic d);
    check = 1'b1;
    tick();
    check = 1'b0;
    l = 1;
    while (!done && l < 40) begin
      tick();
      l++;
    end
    d = died;
    tick();
  endtask

  task automatic count_done(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done) c++;
    end
  endtask

  task automatic greset();
    game_reset = 1'b1;
    tick();
    game_reset = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; game_reset = 1'b0; playing = 1'b1; check = 1'b0; jump = 1'b0;
    obs = '0; lane = 2'd1;
    tick(); tick();
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_died", died, 0);
    chk("rst_idx", hit_index, 0); chk("rst_type", hit_type, 0);
    chk("rst_air", airborne, 0); chk("rst_ovr", overrun, 0);
    rst_n = 1'b1;
    tick();

    obs[0] = mk(OBS_LOW, 11'd20, 2'd1);
    do_check(lat, died_at_done);
    chk("low_latency", lat, 11); chk("low_died_at_done", died_at_done, 1);
    chk("low_idx", hit_index, 0); chk("low_type", hit_type, 0);
    chk("low_done_one_cycle", done, 0); chk("low_busy_idle", busy, 0);

    greset();
    chk("greset_died", died, 0);
    jump = 1'b1; tick(); jump = 1'b0;
    chk("jump_air", airborne, 1);
    for (int i = 0; i < 8; i++) do_check(lat, died_at_done);
    chk("jump_survive", died, 0); chk("jump_landed", airborne, 0);
    do_check(lat, died_at_done);
    chk("jump_ninth_dies", died, 1);

    greset();
    obs = '0; lane = 2'd2;
    obs[3] = mk(OBS_TALL, 11'd40, 2'd2);
    obs[7] = mk(OBS_TALL, 11'd0, 2'd2);
    do_check(lat, died_at_done);
    chk("tall_died", died, 1); chk("tall_idx", hit_index, 3); chk("tall_type", hit_type, 1);
    greset();
    obs[3].position = 11'd41; obs[7].position = 11'd41;
    do_check(lat, died_at_done);
    chk("pos41_alive", died, 0);

    obs = '0;
    obs[4] = mk(OBS_PICKUP, 11'd10, 2'd2);
    do_check(lat, died_at_done);
    chk("pickup_alive", died, 0); chk("pickup_latency", lat, 11);
    obs = '0; lane = 2'd1; playing = 1'b0;
    obs[0] = mk(OBS_LOW, 11'd20, 2'd1);
    do_check(lat, died_at_done);
    chk("notplaying_alive", died, 0); chk("notplaying_latency", lat, 11);

    game_reset = 1'b1; check = 1'b1; tick(); game_reset = 1'b0; check = 1'b0;
    chk("greset_wins_busy", busy, 0); chk("greset_wins_ovr", overrun, 0);

    playing = 1'b1; obs = '0;
    obs[5] = mk(OBS_TALL, 11'd30, 2'd1);
    check = 1'b1; tick(); check = 1'b0;
    tick(); tick(); tick(); tick();
    check = 1'b1; tick(); check = 1'b0;
    chk("overrun_set", overrun, 1);
    count_done(20, pulses);
    chk("overrun_one_done", pulses, 1);
    chk("overrun_died", died, 1); chk("overrun_idx", hit_index, 5);
    chk("overrun_sticky", overrun, 1);

    jump = 1'b1; tick(); jump = 1'b0;
    check = 1'b1; tick(); check = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    game_reset = 1'b1; tick(); game_reset = 1'b0;
    chk("gabort_died", died, 0); chk("gabort_idx", hit_index, 0);
    chk("gabort_ovr", overrun, 0); chk("gabort_air", airborne, 0); chk("gabort_busy", busy, 0);
    count_done(15, pulses);
    chk("gabort_no_done", pulses, 0);

    do_check(lat, died_at_done);
    chk("redie", died, 1);
    jump = 1'b1; tick(); jump = 1'b0;
    check = 1'b1; tick(); check = 1'b0;
    tick(); tick(); tick(); tick();
    check = 1'b1; tick(); check = 1'b0;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rabort_died", died, 0); chk("rabort_idx", hit_index, 0);
    chk("rabort_ovr", overrun, 0); chk("rabort_air", airborne, 0); chk("rabort_busy", busy, 0);
    count_done(15, pulses);
    chk("rabort_no_done", pulses, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
